// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch time interface and its 7-segment display.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_BAD   = 2'b11
   } status_e;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   localparam logic [7:0] MAX_MIN = 8'd99;

   // BCD digit to segment pattern; non-decimal codes render blank
   function automatic logic [6:0] seg_font(input logic [3:0] digit);
      logic [6:0] pat;
      unique case (digit)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_BLANK;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/stopwatch_display_if.sv
// Time interface from the stopwatch core plus the display pins it drives.
interface stopwatch_display_if;
   logic [7:0] minutes;
   logic [5:0] seconds;
   logic [1:0] status;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   modport master (output minutes, seconds, status, input an, seg, dp);
   modport slave  (input minutes, seconds, status, output an, seg, dp);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary (value <= 99) to two BCD digits.
// start loads the value; done pulses for one cycle 8 cycles later.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | eight add-3/shift iterations
// DONE  | result valid, done high for one cycle
module bin2bcd_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] bin,
   output logic       done,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

   state_e      state_q;
   logic [15:0] sr_q;
   logic [2:0]  cnt_q;
   logic        done_q;

   // One add-3 correction on both BCD nibbles followed by a left shift
   function automatic logic [15:0] dabble_step(input logic [15:0] sr);
      logic [3:0] t;
      logic [3:0] o;
      t = sr[15:12];
      o = sr[11:8];
      if (t >= 4'd5) t = t + 4'd3;
      if (o >= 4'd5) o = o + 4'd3;
      return {t, o, sr[7:0]} << 1;
   endfunction

   // Converter FSM; starts outside IDLE are ignored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  sr_q    <= {8'h00, bin};
                  cnt_q   <= '0;
                  state_q <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               sr_q  <= dabble_step(sr_q);
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign done = done_q;
   assign tens = sr_q[15:12];
   assign ones = sr_q[11:8];

endmodule

// File: rtl/stopwatch_display.sv
// Multiplexed MM.SS display: per-frame snapshot, BCD conversion, colon and
// pause blinking. The converters' load registers hold the frame snapshot of
// minutes/seconds; only the status needs its own latch.
module stopwatch_display #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 25000000
) (
   input logic                clk,
   input logic                rst,
   stopwatch_display_if.slave bus
);
   import stopwatch_pkg::*;

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [SW-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_q, blink_d;
   status_e       st_q, st_d;
   logic [15:0]   bcd_q, bcd_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic       scan_tc, blink_tc, frame_wrap;
   logic [7:0] min_clamped, sec_ext;
   logic       min_done, sec_done;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic [3:0] cur_digit;

   assign scan_tc     = (scan_cnt_q == SCAN_LAST);
   assign blink_tc    = (blink_cnt_q == BLINK_LAST);
   assign frame_wrap  = scan_tc && (idx_q == 2'd3);
   assign min_clamped = (bus.minutes > MAX_MIN) ? MAX_MIN : bus.minutes;
   assign sec_ext     = {2'b00, bus.seconds};

   bin2bcd_seq u_min_bcd (
      .clk   (clk),
      .rst   (rst),
      .start (frame_wrap),
      .bin   (min_clamped),
      .done  (min_done),
      .tens  (min_tens),
      .ones  (min_ones)
   );

   bin2bcd_seq u_sec_bcd (
      .clk   (clk),
      .rst   (rst),
      .start (frame_wrap),
      .bin   (sec_ext),
      .done  (sec_done),
      .tens  (sec_tens),
      .ones  (sec_ones)
   );

   // Scan/blink timers, status snapshot and displayed-digit load
   always_comb begin
      scan_cnt_d  = scan_tc ? '0 : scan_cnt_q + SW'(1);
      idx_d       = scan_tc ? idx_q + 2'd1 : idx_q;
      blink_cnt_d = blink_tc ? '0 : blink_cnt_q + BW'(1);
      blink_d     = blink_tc ? ~blink_q : blink_q;
      st_d        = frame_wrap ? status_e'(bus.status) : st_q;
      bcd_d       = (min_done && sec_done) ?
                    {min_tens, min_ones, sec_tens, sec_ones} : bcd_q;
   end

   // Drive pins for the current digit index
   always_comb begin
      unique case (idx_q)
         2'd0:    cur_digit = bcd_q[3:0];
         2'd1:    cur_digit = bcd_q[7:4];
         2'd2:    cur_digit = bcd_q[11:8];
         default: cur_digit = bcd_q[15:12];
      endcase
      an_d  = ~(4'b0001 << idx_q);
      seg_d = seg_font(cur_digit);
      dp_d  = 1'b1;
      unique case (st_q)
         ST_RUN:   dp_d = (idx_q != 2'd2);
         ST_PAUSE: begin
            if (blink_q) an_d = 4'hF;
            else         dp_d = (idx_q != 2'd2);
         end
         ST_BAD:   seg_d = SEG_DASH;
         default:  ;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt_q  <= '0;
         idx_q       <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
         st_q        <= ST_IDLE;
         bcd_q       <= '0;
         an_q        <= 4'hF;
         seg_q       <= SEG_BLANK;
         dp_q        <= 1'b1;
      end else begin
         scan_cnt_q  <= scan_cnt_d;
         idx_q       <= idx_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
         st_q        <= st_d;
         bcd_q       <= bcd_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Bench for stopwatch_display: cycle-accurate reference model checked every
// cycle, a table of display patterns, and hand-written corner sequences.
module tb_stopwatch_display;

   localparam int SCAN_DIV  = 4;
   localparam int BLINK_DIV = 64;
   localparam int FRAME     = 4 * SCAN_DIV;

   localparam logic [6:0] FONT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   logic clk = 1'b0;
   logic rst = 1'b1;
   stopwatch_display_if sw_if ();

   stopwatch_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sw_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
      end
   endtask

   // Reference model: c = clock edges since reset; digit index, blink phase
   // and frame boundaries follow from c by division. The display value
   // becomes the frame snapshot 9 edges after the boundary; pins show the
   // state as it was one edge earlier.
   int c = 0;
   int disp_min = 0, disp_sec = 0, m_st = 0;
   int pend_min = 0, pend_sec = 0, pend_due = -1;
   logic [3:0] exp_an  = 4'hF;
   logic [6:0] exp_seg = 7'h7F;
   logic       exp_dp  = 1'b1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         c = 0; disp_min = 0; disp_sec = 0; m_st = 0; pend_due = -1;
         exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end else begin
         int i, ph, d;
         i  = (c / SCAN_DIV) % 4;
         ph = (c / BLINK_DIV) % 2;
         case (i)
            0:       d = disp_sec % 10;
            1:       d = disp_sec / 10;
            2:       d = disp_min % 10;
            default: d = disp_min / 10;
         endcase
         exp_an = 4'hF;
         exp_an[i] = 1'b0;
         exp_seg = FONT[d];
         exp_dp = 1'b1;
         if (m_st == 1) exp_dp = (i != 2);
         if (m_st == 2) begin
            if (ph == 1) exp_an = 4'hF;
            else exp_dp = (i != 2);
         end
         if (m_st == 3) exp_seg = 7'h3F;
         c++;
         if (c == pend_due) begin
            disp_min = pend_min;
            disp_sec = pend_sec;
         end
         if (c % FRAME == 0) begin
            m_st     = int'(sw_if.status);
            pend_min = (sw_if.minutes > 8'd99) ? 99 : int'(sw_if.minutes);
            pend_sec = int'(sw_if.seconds);
            pend_due = c + 9;
         end
      end
   end

   // Continuous comparison against the model
   always @(negedge clk) begin
      chk("model_an", {12'h0, sw_if.an}, {12'h0, exp_an});
      chk("model_seg", {9'h0, sw_if.seg}, {9'h0, exp_seg});
      chk("model_dp", {15'h0, sw_if.dp}, {15'h0, exp_dp});
   end

   typedef struct {
      logic [7:0]  mn;
      logic [5:0]  sc;
      logic [1:0]  st;
      logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
      logic        dp2;    // dp while digit 2 is lit
   } vec_t;

   vec_t tbl [7];

   task automatic set_in(input int mn, input int sc, input int st);
      sw_if.minutes = 8'(mn);
      sw_if.seconds = 6'(sc);
      sw_if.status  = 2'(st);
   endtask

   initial begin
      int idx, blanks;
      logic [3:0] an_seq [4];
      an_seq[0] = 4'hE; an_seq[1] = 4'hD; an_seq[2] = 4'hB; an_seq[3] = 4'h7;

      tbl[0] = '{8'd0,   6'd0,  2'd0, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b1};
      tbl[1] = '{8'd12,  6'd34, 2'd1, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0};
      tbl[2] = '{8'd150, 6'd7,  2'd1, {7'h10, 7'h10, 7'h40, 7'h78}, 1'b0};
      tbl[3] = '{8'd99,  6'd59, 2'd0, {7'h10, 7'h10, 7'h12, 7'h10}, 1'b1};
      tbl[4] = '{8'd5,   6'd63, 2'd1, {7'h40, 7'h12, 7'h02, 7'h30}, 1'b0};
      tbl[5] = '{8'd42,  6'd17, 2'd3, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1};
      tbl[6] = '{8'd86,  6'd8,  2'd1, {7'h00, 7'h02, 7'h40, 7'h00}, 1'b0};

      // Reset state, then first frame shows 00.00 with colon off
      set_in(0, 0, 0);
      repeat (2) @(negedge clk);
      chk("rst_an", {12'h0, sw_if.an}, 16'h000F);
      chk("rst_seg", {9'h0, sw_if.seg}, 16'h007F);
      chk("rst_dp", {15'h0, sw_if.dp}, 16'h0001);
      rst = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
         @(negedge clk);
         chk("first_an", {12'h0, sw_if.an}, {12'h0, an_seq[k / SCAN_DIV]});
         chk("first_seg", {9'h0, sw_if.seg}, 16'h0040);
         chk("first_dp", {15'h0, sw_if.dp}, 16'h0001);
      end

      // Table of steady display patterns
      for (int v = 0; v < 7; v++) begin
         set_in(int'(tbl[v].mn), int'(tbl[v].sc), int'(tbl[v].st));
         repeat (40) @(negedge clk);
         for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            case (sw_if.an)
               4'hE: idx = 0;
               4'hD: idx = 1;
               4'hB: idx = 2;
               4'h7: idx = 3;
               default: idx = -1;
            endcase
            if (idx < 0) begin
               chk("tbl_an_valid", {12'h0, sw_if.an}, 16'h000E);
            end else begin
               chk("tbl_seg", {9'h0, sw_if.seg}, {9'h0, tbl[v].segs[idx*7 +: 7]});
               chk("tbl_dp", {15'h0, sw_if.dp}, {15'h0, (idx == 2) ? tbl[v].dp2 : 1'b1});
            end
         end
      end

      // Mid-frame change: no tearing, new seconds digit appears a frame later
      set_in(12, 34, 1);
      repeat (40) @(negedge clk);
      for (int k = 0; k < 2 * FRAME && (c % FRAME) != 5; k++) @(negedge clk);
      chk("mid_align", 16'(c % FRAME), 16'd5);
      sw_if.seconds = 6'd35;
      repeat (13) @(negedge clk);
      chk("mid_old_an", {12'h0, sw_if.an}, 16'h000E);
      chk("mid_old_seg", {9'h0, sw_if.seg}, 16'h0019);
      repeat (FRAME) @(negedge clk);
      chk("mid_new_an", {12'h0, sw_if.an}, 16'h000E);
      chk("mid_new_seg", {9'h0, sw_if.seg}, 16'h0012);

      // Paused: half of any 4 blink half-periods is blanked
      sw_if.status = 2'd2;
      repeat (20) @(negedge clk);
      blanks = 0;
      for (int k = 0; k < 4 * BLINK_DIV; k++) begin
         @(negedge clk);
         if (sw_if.an == 4'hF) blanks++;
      end
      chk("pause_blank_cycles", 16'(blanks), 16'(2 * BLINK_DIV));

      // Reset 3 cycles into a conversion
      set_in(47, 29, 1);
      repeat (40) @(negedge clk);
      for (int k = 0; k < 2 * FRAME && (c % FRAME) != 3; k++) @(negedge clk);
      chk("rstmid_align", 16'(c % FRAME), 16'd3);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_an", {12'h0, sw_if.an}, 16'h000F);
      chk("rstmid_seg", {9'h0, sw_if.seg}, 16'h007F);
      chk("rstmid_dp", {15'h0, sw_if.dp}, 16'h0001);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < SCAN_DIV; k++) begin
         @(negedge clk);
         chk("rstmid_zero_an", {12'h0, sw_if.an}, 16'h000E);
         chk("rstmid_zero_seg", {9'h0, sw_if.seg}, 16'h0040);
      end

      // Random inputs against the model
      for (int k = 0; k < 1500; k++) begin
         @(negedge clk);
         if ($urandom_range(0, 19) == 0) begin
            sw_if.minutes = 8'($urandom_range(0, 255));
            sw_if.seconds = 6'($urandom_range(0, 63));
            sw_if.status  = 2'($urandom_range(0, 3));
         end
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
